// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM states and register-index constants.
package pipe_pkg;

   localparam int unsigned REG_W = 5;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      DRAIN    = 2'd2
   } pipe_state_t;

   localparam logic [REG_W-1:0] REG_X0 = 5'd0;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard inputs and per-stage enable/flush controls exchanged between the pipeline and pipe_ctrl.
interface pipe_ctrl_if #(
   parameter int unsigned CNT_W = 32
);
   import pipe_pkg::*;

   logic             id_valid;
   logic [REG_W-1:0] id_rs1;
   logic [REG_W-1:0] id_rs2;
   logic             id_uses_rs1;
   logic             id_uses_rs2;
   logic             id_fence;
   logic             ex_mem_read;
   logic [REG_W-1:0] ex_rd;
   logic             ex_branch_taken;
   logic             mem_req;
   logic             dmem_ready;

   logic             pc_en;
   logic             if_id_en;
   logic             id_ex_en;
   logic             ex_mem_en;
   logic             mem_wb_en;
   logic             pc_redirect;
   logic             if_id_flush;
   logic             id_ex_flush;
   logic             mem_wb_flush;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_fence,
             ex_mem_read, ex_rd, ex_branch_taken, mem_req, dmem_ready,
      input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, pc_redirect,
             if_id_flush, id_ex_flush, mem_wb_flush, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_fence,
             ex_mem_read, ex_rd, ex_branch_taken, mem_req, dmem_ready,
      output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, pc_redirect,
             if_id_flush, id_ex_flush, mem_wb_flush, stall_cnt, flush_cnt
   );

endinterface

// File: rtl/pipe_ctrl_hazard.sv
// Load-use comparator: a valid load in EX writes a register the ID instruction actually reads.
module pipe_ctrl_hazard
   import pipe_pkg::*;
(
   input  logic             i_ex_mem_read,
   input  logic             i_ex_v,
   input  logic [REG_W-1:0] i_ex_rd,
   input  logic [REG_W-1:0] i_id_rs1,
   input  logic [REG_W-1:0] i_id_rs2,
   input  logic             i_id_uses_rs1,
   input  logic             i_id_uses_rs2,
   output logic             o_load_use_c
);

   logic w_rs1_hit;
   logic w_rs2_hit;

   assign w_rs1_hit    = i_id_uses_rs1 & (i_ex_rd == i_id_rs1);
   assign w_rs2_hit    = i_id_uses_rs2 & (i_ex_rd == i_id_rs2);
   // x0 is never a real producer, so a load to x0 cannot create a hazard
   assign o_load_use_c = i_ex_mem_read & i_ex_v & (i_ex_rd != REG_X0) & (w_rs1_hit | w_rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline (mem wait > branch > load-use > fence drain).
// Performance counters are built only when PIPE_CTRL_PERF_EN is defined; otherwise tied to zero.
module pipe_ctrl
   import pipe_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic      clk,
   input  logic      reset,
   pipe_ctrl_if.slave io_pipe
);

   pipe_state_t r_state;
   pipe_state_t w_next;
   logic        r_ex_v;
   logic        r_mem_v;
   logic        r_wb_v;

   logic w_load_use;
   logic w_mem_wait;
   logic w_branch;
   logic w_older_v;
   logic w_fence_block;

   logic w_pc_en;
   logic w_if_id_en;
   logic w_id_ex_en;
   logic w_ex_mem_en;
   logic w_mem_wb_en;
   logic w_pc_redirect;
   logic w_if_id_flush;
   logic w_id_ex_flush;
   logic w_mem_wb_flush;

   pipe_ctrl_hazard u_hazard (
      .i_ex_mem_read (io_pipe.ex_mem_read),
      .i_ex_v        (r_ex_v),
      .i_ex_rd       (io_pipe.ex_rd),
      .i_id_rs1      (io_pipe.id_rs1),
      .i_id_rs2      (io_pipe.id_rs2),
      .i_id_uses_rs1 (io_pipe.id_uses_rs1),
      .i_id_uses_rs2 (io_pipe.id_uses_rs2),
      .o_load_use_c  (w_load_use)
   );

   assign w_mem_wait    = io_pipe.mem_req & ~io_pipe.dmem_ready;
   assign w_branch      = io_pipe.ex_branch_taken & r_ex_v;
   assign w_older_v     = r_ex_v | r_mem_v | r_wb_v;
   assign w_fence_block = io_pipe.id_fence & io_pipe.id_valid & w_older_v;

   // Next state and stage controls, highest-priority event first
   always_comb begin
      w_next         = r_state;
      w_pc_en        = 1'b1;
      w_if_id_en     = 1'b1;
      w_id_ex_en     = 1'b1;
      w_ex_mem_en    = 1'b1;
      w_mem_wb_en    = 1'b1;
      w_pc_redirect  = 1'b0;
      w_if_id_flush  = 1'b0;
      w_id_ex_flush  = 1'b0;
      w_mem_wb_flush = 1'b0;
      if (reset) begin
         w_next         = RUN;
         w_pc_en        = 1'b0;
         w_if_id_flush  = 1'b1;
         w_id_ex_flush  = 1'b1;
         w_mem_wb_flush = 1'b1;
      end else if (w_mem_wait) begin
         w_next         = (r_state == DRAIN) ? DRAIN : MEM_WAIT;
         w_pc_en        = 1'b0;
         w_if_id_en     = 1'b0;
         w_id_ex_en     = 1'b0;
         w_ex_mem_en    = 1'b0;
         w_mem_wb_flush = 1'b1;
      end else if (w_branch) begin
         w_next        = RUN;
         w_pc_redirect = 1'b1;
         w_if_id_flush = 1'b1;
         w_id_ex_flush = 1'b1;
      end else if ((r_state == DRAIN) && !w_older_v) begin
         w_next = RUN;
      end else if ((r_state == DRAIN) || w_load_use || w_fence_block) begin
         // Hold fetch/decode and feed a bubble into EX
         w_next        = ((r_state == DRAIN) || (!w_load_use)) ? DRAIN : RUN;
         w_pc_en       = 1'b0;
         w_if_id_en    = 1'b0;
         w_id_ex_flush = 1'b1;
      end else begin
         w_next = RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= RUN;
         r_ex_v  <= 1'b0;
         r_mem_v <= 1'b0;
         r_wb_v  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_id_ex_en)  r_ex_v  <= io_pipe.id_valid & ~w_id_ex_flush;
         if (w_ex_mem_en) r_mem_v <= r_ex_v;
         if (w_mem_wb_en) r_wb_v  <= r_mem_v & ~w_mem_wb_flush;
      end
   end

   assign io_pipe.pc_en        = w_pc_en;
   assign io_pipe.if_id_en     = w_if_id_en;
   assign io_pipe.id_ex_en     = w_id_ex_en;
   assign io_pipe.ex_mem_en    = w_ex_mem_en;
   assign io_pipe.mem_wb_en    = w_mem_wb_en;
   assign io_pipe.pc_redirect  = w_pc_redirect;
   assign io_pipe.if_id_flush  = w_if_id_flush;
   assign io_pipe.id_ex_flush  = w_id_ex_flush;
   assign io_pipe.mem_wb_flush = w_mem_wb_flush;

`ifdef PIPE_CTRL_PERF_EN
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (!w_pc_en)      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (w_pc_redirect) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign io_pipe.stall_cnt = r_stall_cnt;
   assign io_pipe.flush_cnt = r_flush_cnt;
`else
   localparam logic [CNT_W-1:0] ZERO_CNT = '0;

   assign io_pipe.stall_cnt = ZERO_CNT;
   assign io_pipe.flush_cnt = ZERO_CNT;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: each driven cycle pushes its expected control vector, a monitor pops and compares.
module tb_pipe_ctrl;

   localparam int unsigned CNT_W = 32;

   // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, pc_redirect, if_id_flush, id_ex_flush, mem_wb_flush}
   localparam logic [8:0] V_RUN = 9'b111110000;
   localparam logic [8:0] V_RST = 9'b011110111;
   localparam logic [8:0] V_HLD = 9'b001110010;
   localparam logic [8:0] V_BR  = 9'b111111110;
   localparam logic [8:0] V_MW  = 9'b000010001;

   logic clk;
   logic reset;

   pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

   pipe_ctrl #(.CNT_W(CNT_W)) u_dut (
      .clk     (clk),
      .reset   (reset),
      .io_pipe (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_cmp;
   int unsigned n_fail;

   logic [8:0]  q_exp [$];
   string       q_tag [$];
   logic        q_rst [$];

   logic [31:0] m_stall;
   logic [31:0] m_flush;
   logic [8:0]  mon_exp;
   string       mon_tag;
   logic        mon_rst;
   logic [8:0]  mon_obs;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic nxt();
      @(negedge clk);
      reset               = 1'b0;
      bus.id_valid        = 1'b0;
      bus.id_rs1          = 5'd0;
      bus.id_rs2          = 5'd0;
      bus.id_uses_rs1     = 1'b0;
      bus.id_uses_rs2     = 1'b0;
      bus.id_fence        = 1'b0;
      bus.ex_mem_read     = 1'b0;
      bus.ex_rd           = 5'd0;
      bus.ex_branch_taken = 1'b0;
      bus.mem_req         = 1'b0;
      bus.dmem_ready      = 1'b0;
   endtask

   task automatic push(input logic [8:0] exp, input string tag);
      q_exp.push_back(exp);
      q_tag.push_back(tag);
      q_rst.push_back(reset);
   endtask

   // Monitor: compare the cycle's controls and the counters against the bench model
   always @(negedge clk) begin
      #2;
      if (q_exp.size() != 0) begin
         mon_exp = q_exp.pop_front();
         mon_tag = q_tag.pop_front();
         mon_rst = q_rst.pop_front();
         mon_obs = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
                    bus.pc_redirect, bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_flush};
         check(mon_tag, 32'(mon_obs), 32'(mon_exp));
         if (mon_rst) begin
            m_stall = 32'd0;
            m_flush = 32'd0;
         end else begin
            check({mon_tag, ".stall_cnt"}, bus.stall_cnt, m_stall);
            check({mon_tag, ".flush_cnt"}, bus.flush_cnt, m_flush);
`ifdef PIPE_CTRL_PERF_EN
            if (!mon_exp[8]) m_stall = m_stall + 32'd1;
            if (mon_exp[3])  m_flush = m_flush + 32'd1;
`endif
         end
      end
   end

   initial begin
      n_cmp   = 0;
      n_fail  = 0;
      m_stall = 32'd0;
      m_flush = 32'd0;
      reset               = 1'b1;
      bus.id_valid        = 1'b0;
      bus.id_rs1          = 5'd0;
      bus.id_rs2          = 5'd0;
      bus.id_uses_rs1     = 1'b0;
      bus.id_uses_rs2     = 1'b0;
      bus.id_fence        = 1'b0;
      bus.ex_mem_read     = 1'b0;
      bus.ex_rd           = 5'd0;
      bus.ex_branch_taken = 1'b0;
      bus.mem_req         = 1'b0;
      bus.dmem_ready      = 1'b0;

      for (int i = 0; i < 2; i++) begin
         nxt(); reset = 1'b1; push(V_RST, "reset");
      end

      // Load-use via rs2, then EX bubble must not re-stall
      nxt(); bus.id_valid = 1'b1; push(V_RUN, "plain0");
      nxt(); bus.id_valid = 1'b1; bus.id_rs2 = 5'd5; bus.id_uses_rs2 = 1'b1;
             bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd5; push(V_HLD, "lu_rs2");
      nxt(); bus.id_valid = 1'b1; bus.id_rs2 = 5'd5; bus.id_uses_rs2 = 1'b1;
             bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd5; push(V_RUN, "lu_after");
      nxt(); bus.id_valid = 1'b1; bus.id_uses_rs1 = 1'b1; bus.id_uses_rs2 = 1'b1;
             bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd0; push(V_RUN, "lu_x0");
      nxt(); bus.id_valid = 1'b1; bus.id_rs1 = 5'd7;
             bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd7; push(V_RUN, "lu_unused");
      nxt(); bus.id_valid = 1'b1; bus.id_rs1 = 5'd9; bus.id_uses_rs1 = 1'b1;
             bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd9; push(V_HLD, "lu_rs1");
      nxt(); bus.id_valid = 1'b1; push(V_RUN, "plain1");

      // Branch wins over a simultaneous load-use; branch with empty EX is ignored
      nxt(); bus.id_valid = 1'b1; bus.id_rs1 = 5'd3; bus.id_uses_rs1 = 1'b1;
             bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd3; bus.ex_branch_taken = 1'b1;
             push(V_BR, "br_lu");
      nxt(); bus.id_valid = 1'b1; bus.ex_branch_taken = 1'b1; push(V_RUN, "br_ex_bubble");

      // Memory wait holds a pending branch until dmem_ready
      for (int i = 0; i < 3; i++) begin
         nxt(); bus.id_valid = 1'b1; bus.ex_branch_taken = 1'b1; bus.mem_req = 1'b1;
         push(V_MW, "mem_wait");
      end
      nxt(); bus.id_valid = 1'b1; bus.ex_branch_taken = 1'b1; bus.mem_req = 1'b1;
             bus.dmem_ready = 1'b1; push(V_BR, "mem_release_br");
      nxt(); push(V_RUN, "idle0");
      nxt(); push(V_RUN, "idle1");

      // Fence with an empty pipeline passes; with three older it drains three cycles
      nxt(); bus.id_valid = 1'b1; bus.id_fence = 1'b1; push(V_RUN, "fence_empty");
      nxt(); bus.id_valid = 1'b1; push(V_RUN, "plain2");
      nxt(); bus.id_valid = 1'b1; push(V_RUN, "plain3");
      for (int i = 0; i < 3; i++) begin
         nxt(); bus.id_valid = 1'b1; bus.id_fence = 1'b1; push(V_HLD, "drain");
      end
      nxt(); bus.id_valid = 1'b1; bus.id_fence = 1'b1; push(V_RUN, "fence_go");

      // Drain stretched by a memory wait, then reset in the middle of DRAIN
      nxt(); bus.id_valid = 1'b1; push(V_RUN, "plain4");
      nxt(); bus.id_valid = 1'b1; push(V_RUN, "plain5");
      nxt(); bus.id_valid = 1'b1; bus.id_fence = 1'b1; push(V_HLD, "drain_in");
      nxt(); bus.id_valid = 1'b1; bus.id_fence = 1'b1; bus.mem_req = 1'b1;
             push(V_MW, "drain_mw");
      nxt(); bus.id_valid = 1'b1; bus.id_fence = 1'b1; push(V_HLD, "drain_hold");
      nxt(); reset = 1'b1; bus.id_valid = 1'b1; bus.id_fence = 1'b1; push(V_RST, "drain_rst");
      nxt(); bus.id_valid = 1'b1; bus.id_fence = 1'b1; push(V_RUN, "post_rst_fence");
      nxt(); push(V_RUN, "post_rst_idle");

      nxt();
      nxt();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central stall/flush sequencer for the 5-stage RV32 pipeline. It combines load-use detection, EX-stage branch redirects, data-memory wait states and FENCE draining into one set of per-stage enable and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It replaces scattered per-hazard logic in the top level and sits beside the forwarding unit, driving every pipeline register.

## Interface
- Parameters:
- CNT_W, default 32: width of the performance counters.
- Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous reset, active-high
- id_valid  in  1  ID stage holds a real instruction
- id_rs1, id_rs2  in  5 each  ID source registers
- id_uses_rs1, id_uses_rs2  in  1 each  ID instruction actually reads that source
- id_fence  in  1  ID instruction is FENCE
- ex_mem_read  in  1  EX instruction is a load
- ex_rd  in  5  EX destination register
- ex_branch_taken  in  1  EX resolved a taken branch or jump (redirect)
- mem_req  in  1  MEM instruction accesses data memory this cycle
- dmem_ready  in  1  data memory completes the access this cycle
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register load enables
- pc_redirect  out  1  PC selects branch target
- if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  load a bubble (valid=0)
- stall_cnt, flush_cnt  out  CNT_W each  performance counters (PIPE_CTRL_PERF_EN only)

## Operation
- Internal state: FSM {RUN, MEM_WAIT, DRAIN}; shadow valid bits ex_v, mem_v, wb_v for the ID/EX, EX/MEM and MEM/WB contents.
- Shadow valid update, every cycle, when the corresponding enable is high:
- ex_v <= id_valid & ~id_ex_flush
- mem_v <= ex_v
- wb_v <= mem_v & ~mem_wb_flush
- Load-use hazard: ex_mem_read & ex_v & ex_rd!=0 & ((id_uses_rs1 & ex_rd==id_rs1) | (id_uses_rs2 & ex_rd==id_rs2)).
- Priority, highest first:
- Memory wait: mem_req & ~dmem_ready. Freeze pc, IF/ID, ID/EX and EX/MEM. Set mem_wb_flush=1. Any branch or hazard stays pending and re-evaluates later.
- Branch: ex_branch_taken & ex_v. pc_redirect=1 and all enables high. Set if_id_flush=1 and id_ex_flush=1. Any load-use or fence in ID is discarded.
- Load-use: pc_en=0 and if_id_en=0. Set id_ex_flush=1 for exactly one cycle.
- Fence: id_fence & id_valid & (ex_v|mem_v|wb_v). Enter DRAIN.
- FSM transitions:
- RUN -> MEM_WAIT when a memory wait begins.
- MEM_WAIT -> RUN in the cycle dmem_ready=1. That cycle runs with RUN priorities.
- RUN -> DRAIN on fence with an older valid instruction.
- In DRAIN: pc and IF/ID are held, id_ex_flush=1, and memory waits are still honoured. DRAIN -> RUN when ex_v=mem_v=wb_v=0. The fence then advances on that cycle.
- A fence with no older valid instructions passes with no stall.
- Default in RUN with no event: all enables 1, all flushes 0, pc_redirect 0.

## Timing
- All outputs are combinational from state and inputs, with zero-cycle latency. State updates on the rising edge of clk.
- Reset: state=RUN, ex_v=mem_v=wb_v=0, counters=0. While reset is high, outputs are pc_en=0, pc_redirect=0, all flushes=1, and the other enables=1.
- Load-use inserts exactly one bubble. A back-to-back dependent load pair costs 1 cycle each.
- A branch costs 2 bubbles. A branch with mem wait is delayed until dmem_ready, then flushes on the release cycle.
- The DRAIN length equals the number of valid older instructions plus any memory wait cycles.
- Asserting reset during MEM_WAIT or DRAIN returns to RUN on the next edge.

## Configuration
- PIPE_CTRL_PERF_EN defined:
- stall_cnt increments on every cycle with pc_en=0 and reset low.
- flush_cnt increments on every branch redirect.
- Both wrap modulo 2^CNT_W.
- Not defined: the counters are not synthesized and stall_cnt and flush_cnt are tied to 0.

## Structure
- The shared package pipe_pkg holds the FSM state enum pipe_state_t {RUN, MEM_WAIT, DRAIN} and the register index constant REG_X0=5'd0.
- The sub-module pipe_ctrl_hazard is the pure combinational load-use comparator. It is instantiated once and reused by the forwarding-stall path.

## Test plan
- Load to x5 in EX, ID reads x5 via rs2 -> one cycle with pc_en=0, if_id_en=0, id_ex_flush=1, then normal flow.
- Load to x0 in EX, ID reads x0 -> no stall.
- Branch taken with a load-use hazard in the same cycle -> pc_redirect=1, if_id_flush=1, id_ex_flush=1, pc_en=1, no stall; flush_cnt +1.
- mem_req=1, dmem_ready=0 for 3 cycles with ex_branch_taken=1 -> 3 frozen cycles, mem_wb_flush=1 each; redirect occurs on the release cycle; stall_cnt +3.
- FENCE in ID with 3 valid older instructions -> DRAIN for 3 cycles (pc_en=0, id_ex_flush=1), then RUN with the fence advancing.
- Reset asserted mid-DRAIN -> next cycle state=RUN, shadow valids=0, counters=0.
